// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: 2-flop synchronizer, per-bit debounce,
// and a per-bit press/auto-repeat pulse generator driving button_bus.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] btn_raw,
  input  logic [4:0] repeat_en,
  output logic [4:0] button_bus,
  output logic [4:0] btn_level
);

  localparam int NB    = 5;
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_C   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RD_SAT = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_C   = CW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] level_r;
  logic [NB-1:0] bus_r;
  logic [CW-1:0] deb_cnt_r  [NB];
  logic [CW-1:0] hold_cnt_r [NB];
  state_e        state_r    [NB];

  logic [CW-1:0] cnt_inc_s  [NB];
  logic [CW-1:0] hold_inc_s [NB];
  logic [NB-1:0] deb_done_s;
  logic [NB-1:0] rise_s;
  logic [NB-1:0] fall_s;

  assign button_bus = bus_r;
  assign btn_level  = level_r;

  // Debounce decode: rise/fall fire on the edge where btn_level is about to flip.
  always_comb begin
    cnt_inc_s  = '{default: '0};
    hold_inc_s = '{default: '0};
    deb_done_s = '0;
    rise_s     = '0;
    fall_s     = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_inc_s[i]  = deb_cnt_r[i] + CW'(1);
      hold_inc_s[i] = hold_cnt_r[i] + CW'(1);
      deb_done_s[i] = (sync2_r[i] != level_r[i]) && (cnt_inc_s[i] == DEB_C);
      rise_s[i]     = deb_done_s[i] & sync2_r[i];
      fall_s[i]     = deb_done_s[i] & ~sync2_r[i];
    end
  end

  // Synchronizer chain and debounce counters / debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      level_r <= '0;
      for (int i = 0; i < NB; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_done_s[i]) begin
          level_r[i]   <= sync2_r[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= cnt_inc_s[i];
        end
      end
    end
  end

  // Press / auto-repeat FSM per bit; one counter serves as hold and period timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_r <= '0;
      for (int i = 0; i < NB; i++) begin
        state_r[i]    <= IDLE;
        hold_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        bus_r[i] <= 1'b0;
        case (state_r[i])
          IDLE: begin
            hold_cnt_r[i] <= '0;
            if (rise_s[i]) begin
              bus_r[i]   <= 1'b1;
              state_r[i] <= HOLD;
            end
          end
          HOLD: begin
            if (fall_s[i]) begin
              state_r[i]    <= IDLE;
              hold_cnt_r[i] <= '0;
            end else if (hold_inc_s[i] >= RD_C) begin
              // Saturate one below the delay so a late repeat_en fires at once
              if (repeat_en[i] && !bus_r[i]) begin
                bus_r[i]      <= 1'b1;
                state_r[i]    <= REPEAT;
                hold_cnt_r[i] <= '0;
              end else begin
                hold_cnt_r[i] <= RD_SAT;
              end
            end else begin
              hold_cnt_r[i] <= hold_inc_s[i];
            end
          end
          REPEAT: begin
            if (fall_s[i]) begin
              state_r[i]    <= IDLE;
              hold_cnt_r[i] <= '0;
            end else if (!repeat_en[i]) begin
              hold_cnt_r[i] <= '0;
            end else if (hold_inc_s[i] == RP_C) begin
              bus_r[i]      <= 1'b1;
              hold_cnt_r[i] <= '0;
            end else begin
              hold_cnt_r[i] <= hold_inc_s[i];
            end
          end
          default: begin
            state_r[i]    <= IDLE;
            hold_cnt_r[i] <= '0;
          end
        endcase
      end
    end
  end

endmodule
